laser_score: RTL and testbench
==============================

Name: laser_score

Overview:
- Downstream checker that sits directly after the laser-placement engine.
- Snoops the 40-target stream the engine loads, captures the two circle centres when the engine pulses DONE, then counts the targets covered by either circle.
- Presents the coverage count through a valid/ack handshake to the test harness or host.
- Used for on-chip self-check and score logging.

Parameters:
- OBJ_NUM, 40, number of targets per image; must be divisible by PARALLEL.
- PARALLEL, 5, targets evaluated per EVAL cycle.
- CNT_W, 6, count width; must satisfy 2^CNT_W > OBJ_NUM.
- RADIUS_SQ, 16, inclusive squared-radius threshold.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-low.
- IN_VALID  in  1  target sample qualifier; same stream that feeds the engine.
- X  in  4  target x coordinate.
- Y  in  4  target y coordinate.
- DONE  in  1  engine result pulse; C1X/C1Y/C2X/C2Y are valid in the same cycle.
- C1X, C1Y, C2X, C2Y  in  4 each  circle centres.
- SCORE_ACK  in  1  consumer accepts the result.
- SCORE_VALID  out  1  result available.
- SCORE  out  CNT_W  number of targets inside circle 1 or circle 2 (union).
- C1_HITS  out  CNT_W  number of targets inside circle 1.
- C2_HITS  out  CNT_W  number of targets inside circle 2.
- BUSY  out  1  high in EVAL and REPORT.

Behaviour:
- Reset: RST low at a rising edge (synchronous, active-low) forces the following:
  - state LOAD; load counter 0;
  - all outputs 0; target memory content don't-care.
- Reset mid-operation discards any partial load, evaluation or pending report. No SCORE_VALID until a full new load + DONE sequence.
- States:
  - LOAD -> WAIT_DONE when the OBJ_NUM-th IN_VALID sample is written.
  - WAIT_DONE -> EVAL on DONE.
  - EVAL -> REPORT after OBJ_NUM/PARALLEL cycles.
  - REPORT -> LOAD when SCORE_ACK=1.
- LOAD:
  - each cycle with IN_VALID=1 writes {Y,X} to mem[cnt], cnt+1.
  - IN_VALID=0 holds cnt.
  - DONE in LOAD is ignored.
- WAIT_DONE:
  - IN_VALID ignored (extra samples dropped).
  - on DONE, register the four centres; the hit counters and eval index clear to 0.
- EVAL: each cycle processes mem[k..k+PARALLEL-1], k stepping by PARALLEL from 0.
  - per target: dx = cx - x and dy = cy - y as 5-bit signed, no wrap-around (0 vs 15 is distance 15).
  - inside iff dx*dx + dy*dy <= RADIUS_SQ, using an unsigned 9-bit sum.
  - C1_HITS adds the popcount of in1; C2_HITS the popcount of in2; SCORE the popcount of (in1|in2).
  - counters are internal until REPORT; outputs SCORE, C1_HITS and C2_HITS hold 0 during EVAL.
- Latency: DONE sampled at edge t → SCORE_VALID=1 after edge t+OBJ_NUM/PARALLEL+1 (9 cycles at defaults).
- REPORT:
  - SCORE_VALID=1; SCORE, C1_HITS and C2_HITS stable.
  - stay until SCORE_ACK=1; that edge returns to LOAD and clears SCORE_VALID and all counts to 0.
  - SCORE_ACK outside REPORT is ignored.
  - DONE or IN_VALID during EVAL/REPORT are ignored. The next image's stream is lost if it arrives before ACK; the harness must ACK first.
- Simultaneous events:
  - the final LOAD write and DONE in the same cycle: DONE is ignored; the block waits for the next DONE.
  - SCORE_ACK together with IN_VALID in REPORT: the sample is dropped.
- Counts never exceed OBJ_NUM; SCORE <= C1_HITS + C2_HITS; SCORE >= max(C1_HITS, C2_HITS).

Decomposition:
- Shared package laser_pkg:
  - OBJ_NUM, PARALLEL, CNT_W, RADIUS_SQ;
  - state encoding (LOAD, WAIT_DONE, EVAL, REPORT);
  - packed target type {y[3:0], x[3:0]}.
- Sub-module laser_cover_chk, purely combinational, instantiated 2*PARALLEL times:
  - inputs x, y, cx, cy; output inside.
  - reusable by the placement engine for its own inside test.
- Popcount is a small function in laser_pkg.

Test Plan:
- All 40 targets (8,8); DONE with C1=(8,8), C2=(0,0) -> after 9 cycles SCORE_VALID=1, SCORE=40, C1_HITS=40, C2_HITS=0.
- Boundary ring, C1=(8,8), C2=(0,15):
  - 10 each of (10,11), (12,8), (11,11), (8,13);
  - inside: (2,3)=13 and (4,0)=16; outside: (3,3)=18 and (0,5)=25;
  - expect SCORE=20, C1_HITS=20, C2_HITS=0.
- No wrap-around / overlap:
  - 20 targets (0,0) and 20 targets (15,15); C1=C2=(15,15) -> SCORE=20, both hits 20.
  - C1=(1,1), C2=(14,14) -> SCORE=40, C1_HITS=20, C2_HITS=20.
- Handshake and gaps:
  - IN_VALID toggled 1/0 during load; DONE pulsed mid-LOAD is ignored; a real DONE follows.
  - hold SCORE_ACK=0 for 6 cycles -> outputs stable; ACK -> next edge SCORE_VALID=0, counts 0, state LOAD.
- Reset mid-EVAL: RST=0 for 1 cycle at EVAL cycle 4 -> SCORE_VALID never asserts, BUSY=0. A fresh 40-sample load + DONE yields the correct score.
- Back-to-back images: second image loaded after ACK, with different centres -> second score is independent of the first.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared definitions for the laser placement checker: sizing, FSM states,
// packed target type and a popcount helper.
package laser_pkg;

    localparam int OBJ_NUM     = 40;
    localparam int PARALLEL    = 5;
    localparam int CNT_W       = 6;
    localparam int RADIUS_SQ   = 16;
    // Wide enough to hold OBJ_NUM itself, which the eval index reaches at the end
    localparam int IDX_W       = $clog2(OBJ_NUM + 1);

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        WAIT_DONE = 2'd1,
        EVAL      = 2'd2,
        REPORT    = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] y;
        logic [3:0] x;
    } target_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [PARALLEL-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < PARALLEL; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/laser_cover_chk.sv
// Combinational circle-coverage test: is target (x,y) within the inclusive
// squared radius of centre (cx,cy)? Distances do not wrap around the grid.
module laser_cover_chk
    import laser_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [3:0] cx,
    input  logic [3:0] cy,
    output logic       is_inside
);

    logic signed [4:0] dx;
    logic signed [4:0] dy;
    logic signed [9:0] dx_sq;
    logic signed [9:0] dy_sq;
    logic        [9:0] dist_sq;

    // Signed differences squared; the sum peaks at 450 so it never overflows
    always_comb begin
        dx        = $signed({1'b0, cx}) - $signed({1'b0, x});
        dy        = $signed({1'b0, cy}) - $signed({1'b0, y});
        dx_sq     = dx * dx;
        dy_sq     = dy * dy;
        dist_sq   = unsigned'(dx_sq) + unsigned'(dy_sq);
        is_inside = (dist_sq <= 10'(RADIUS_SQ));
    end

endmodule

// File: rtl/laser_score.sv
// Coverage scorer: snoops the target stream, captures both circle centres on
// DONE, counts covered targets PARALLEL per cycle and reports via valid/ack.
module laser_score
    import laser_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    input  logic [3:0]       X,
    input  logic [3:0]       Y,
    input  logic             DONE,
    input  logic [3:0]       C1X,
    input  logic [3:0]       C1Y,
    input  logic [3:0]       C2X,
    input  logic [3:0]       C2Y,
    input  logic             SCORE_ACK,
    output logic             SCORE_VALID,
    output logic [CNT_W-1:0] SCORE,
    output logic [CNT_W-1:0] C1_HITS,
    output logic [CNT_W-1:0] C2_HITS,
    output logic             BUSY
);

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  cnt;
    logic [IDX_W-1:0]  k;
    target_t           mem [OBJ_NUM];
    logic [3:0]        c1x_r, c1y_r, c2x_r, c2y_r;
    logic [PARALLEL-1:0] in1, in2;
    logic [PARALLEL-1:0] hit1_p1, hit2_p1;
    logic              vld_p1, last_p1;
    logic [CNT_W-1:0]  acc1, acc2, accu;
    logic [CNT_W-1:0]  pop1, pop2, popu;
    logic              load_wr, load_last, issue, capture;

    assign load_wr   = (state == LOAD) && IN_VALID;
    assign load_last = load_wr && (cnt == IDX_W'(OBJ_NUM - 1));
    assign capture   = (state == WAIT_DONE) && DONE;
    assign issue     = (state == EVAL) && (k < IDX_W'(OBJ_NUM));

    assign pop1 = popcount(hit1_p1);
    assign pop2 = popcount(hit2_p1);
    assign popu = popcount(hit1_p1 | hit2_p1);

    // Stage p0: read one group of targets and test it against both circles
    for (genvar i = 0; i < PARALLEL; i++) begin : g_chk
        target_t t;
        assign t = mem[k + IDX_W'(i)];
        laser_cover_chk u_c1 (.x(t.x), .y(t.y), .cx(c1x_r), .cy(c1y_r), .is_inside(in1[i]));
        laser_cover_chk u_c2 (.x(t.x), .y(t.y), .cx(c2x_r), .cy(c2y_r), .is_inside(in2[i]));
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) state <= LOAD;
        else      state <= state_nxt;
    end

    // Next-state logic; EVAL ends when the last group has been accumulated
    always_comb begin
        state_nxt = state;
        BUSY      = 1'b0;
        case (state)
            LOAD:      if (load_last) state_nxt = WAIT_DONE;
            WAIT_DONE: if (DONE) state_nxt = EVAL;
            EVAL: begin
                BUSY = 1'b1;
                if (last_p1) state_nxt = REPORT;
            end
            REPORT: begin
                BUSY = 1'b1;
                if (SCORE_ACK) state_nxt = LOAD;
            end
            default:   state_nxt = LOAD;
        endcase
    end

    // Control: load/eval counters, stage-p1 accumulation and result handshake
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt         <= '0;
            k           <= '0;
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
            acc1        <= '0;
            acc2        <= '0;
            accu        <= '0;
            SCORE_VALID <= 1'b0;
            SCORE       <= '0;
            C1_HITS     <= '0;
            C2_HITS     <= '0;
        end else begin
            vld_p1  <= issue;
            last_p1 <= issue && (k == IDX_W'(OBJ_NUM - PARALLEL));
            if (load_wr) cnt <= load_last ? '0 : cnt + IDX_W'(1);
            if (capture) begin
                k    <= '0;
                acc1 <= '0;
                acc2 <= '0;
                accu <= '0;
            end
            if (issue) k <= k + IDX_W'(PARALLEL);
            if (vld_p1) begin
                acc1 <= acc1 + pop1;
                acc2 <= acc2 + pop2;
                accu <= accu + popu;
            end
            if (last_p1) begin
                SCORE_VALID <= 1'b1;
                SCORE       <= accu + popu;
                C1_HITS     <= acc1 + pop1;
                C2_HITS     <= acc2 + pop2;
            end
            if ((state == REPORT) && SCORE_ACK) begin
                SCORE_VALID <= 1'b0;
                SCORE       <= '0;
                C1_HITS     <= '0;
                C2_HITS     <= '0;
            end
        end
    end

    // Data: target memory, captured centres and stage-p1 hit vectors
    always_ff @(posedge CLK) begin
        if (load_wr) mem[cnt] <= target_t'({Y, X});
        if (capture) begin
            c1x_r <= C1X;
            c1y_r <= C1Y;
            c2x_r <= C2X;
            c2y_r <= C2Y;
        end
        if (issue) begin
            hit1_p1 <= in1;
            hit2_p1 <= in2;
        end
    end

endmodule

// File: tb/tb_laser_score.sv
// Scoreboard bench for laser_score: the driver pushes model results into a
// queue, a monitor pops and compares on each rising SCORE_VALID.
module tb_laser_score;
    import laser_pkg::*;

    logic             CLK = 1'b0;
    logic             RST, IN_VALID, DONE, SCORE_ACK;
    logic [3:0]       X, Y, C1X, C1Y, C2X, C2Y;
    logic             SCORE_VALID, BUSY;
    logic [CNT_W-1:0] SCORE, C1_HITS, C2_HITS;

    typedef struct { int s; int h1; int h2; } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   tx[OBJ_NUM];
    int   ty[OBJ_NUM];
    bit   prev_vld = 1'b0;

    laser_score dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .X(X), .Y(Y), .DONE(DONE),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .SCORE_ACK(SCORE_ACK),
        .SCORE_VALID(SCORE_VALID), .SCORE(SCORE), .C1_HITS(C1_HITS),
        .C2_HITS(C2_HITS), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic bit covered(input int x, input int y, input int cx, input int cy);
        return ((cx - x) * (cx - x) + (cy - y) * (cy - y)) <= RADIUS_SQ;
    endfunction

    // Reference: count covered targets straight from the geometric rule
    function automatic exp_t model(input int c1x, input int c1y, input int c2x, input int c2y);
        exp_t e;
        e.s = 0; e.h1 = 0; e.h2 = 0;
        for (int i = 0; i < OBJ_NUM; i++) begin
            bit a, b;
            a = covered(tx[i], ty[i], c1x, c1y);
            b = covered(tx[i], ty[i], c2x, c2y);
            e.h1 += int'(a);
            e.h2 += int'(b);
            e.s  += int'(a | b);
        end
        return e;
    endfunction

    function automatic int clamp16(input int v);
        return (v < 0) ? 0 : ((v > 15) ? 15 : v);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_centres();
        C1X = 4'($urandom); C1Y = 4'($urandom);
        C2X = 4'($urandom); C2Y = 4'($urandom);
    endtask

    task automatic load_image(input bit gaps, input bit mid_done, input bit final_done);
        for (int i = 0; i < OBJ_NUM; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    IN_VALID = 1'b0; X = 4'($urandom); Y = 4'($urandom);
                    tick();
                end
            end
            if (mid_done && i == OBJ_NUM / 2) begin
                IN_VALID = 1'b0; DONE = 1'b1; rand_centres();
                tick();
                DONE = 1'b0;
            end
            IN_VALID = 1'b1; X = 4'(tx[i]); Y = 4'(ty[i]);
            DONE = final_done && (i == OBJ_NUM - 1);
            if (DONE) rand_centres();
            tick();
            DONE = 1'b0;
        end
        // Extra samples while waiting for DONE must be dropped
        repeat (2) begin
            IN_VALID = 1'b1; X = 4'($urandom); Y = 4'($urandom);
            tick();
        end
        IN_VALID = 1'b0;
        check("busy_wait_done", BUSY, 0);
    endtask

    task automatic run_image(input int c1x, input int c1y, input int c2x, input int c2y, input int hold);
        exp_t e;
        int   lat;
        e = model(c1x, c1y, c2x, c2y);
        exp_q.push_back(e);
        C1X = 4'(c1x); C1Y = 4'(c1y); C2X = 4'(c2x); C2Y = 4'(c2y);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        rand_centres();
        lat = 0;
        while (!SCORE_VALID && lat < 40) begin
            IN_VALID = 1'($urandom); DONE = 1'($urandom);
            X = 4'($urandom); Y = 4'($urandom);
            if (lat == 3) begin
                check("busy_eval", BUSY, 1);
                check("score_eval_zero", SCORE, 0);
            end
            tick();
            lat++;
        end
        IN_VALID = 1'b0; DONE = 1'b0;
        check("latency", lat, OBJ_NUM / PARALLEL + 1);
        if (!SCORE_VALID) return;
        repeat (hold) begin
            SCORE_ACK = 1'b0;
            DONE = 1'($urandom);
            check("hold_valid", SCORE_VALID, 1);
            check("hold_score", SCORE, e.s);
            check("hold_c1", C1_HITS, e.h1);
            check("hold_c2", C2_HITS, e.h2);
            tick();
        end
        DONE = 1'b0;
        SCORE_ACK = 1'b1; IN_VALID = 1'b1; X = 4'($urandom); Y = 4'($urandom);
        tick();
        SCORE_ACK = 1'b0; IN_VALID = 1'b0;
        check("ack_valid", SCORE_VALID, 0);
        check("ack_score", SCORE, 0);
        check("ack_c1", C1_HITS, 0);
        check("ack_c2", C2_HITS, 0);
        check("ack_busy", BUSY, 0);
    endtask

    // Monitor: compare each newly presented result with the oldest expectation
    always @(negedge CLK) begin
        if (SCORE_VALID && !prev_vld) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("score", SCORE, mon_e.s);
                check("c1_hits", C1_HITS, mon_e.h1);
                check("c2_hits", C2_HITS, mon_e.h2);
            end
        end
        prev_vld = SCORE_VALID;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_valid, seen_busy;
        int cx, cy;
        RST = 1'b0; IN_VALID = 1'b0; DONE = 1'b0; SCORE_ACK = 1'b0;
        X = '0; Y = '0; C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
        repeat (2) tick();
        RST = 1'b1;
        check("rst_valid", SCORE_VALID, 0);
        check("rst_score", SCORE, 0);
        check("rst_c1", C1_HITS, 0);
        check("rst_c2", C2_HITS, 0);
        check("rst_busy", BUSY, 0);

        // Every target at the first centre
        for (int i = 0; i < OBJ_NUM; i++) begin tx[i] = 8; ty[i] = 8; end
        load_image(1'b0, 1'b0, 1'b0);
        run_image(8, 8, 0, 0, 0);

        // Radius boundary ring around (8,8)
        for (int i = 0; i < OBJ_NUM; i++) begin
            case (i % 4)
                0: begin tx[i] = 10; ty[i] = 11; end
                1: begin tx[i] = 12; ty[i] = 8;  end
                2: begin tx[i] = 11; ty[i] = 11; end
                default: begin tx[i] = 8; ty[i] = 13; end
            endcase
        end
        load_image(1'b1, 1'b0, 1'b0);
        run_image(8, 8, 0, 15, 0);

        // Opposite corners: no wrap-around, then full overlap and disjoint circles
        for (int i = 0; i < OBJ_NUM; i++) begin
            tx[i] = (i < 20) ? 0 : 15; ty[i] = tx[i];
        end
        load_image(1'b0, 1'b0, 1'b1);
        run_image(15, 15, 15, 15, 0);
        load_image(1'b1, 1'b0, 1'b0);
        run_image(1, 1, 14, 14, 0);

        // Gappy load with a stray DONE, then a long hold before ACK
        for (int i = 0; i < OBJ_NUM; i++) begin
            tx[i] = clamp16(6 + int'($urandom_range(0, 8)) - 4);
            ty[i] = clamp16(9 + int'($urandom_range(0, 8)) - 4);
        end
        load_image(1'b1, 1'b1, 1'b0);
        run_image(6, 9, 7, 6, 6);

        // Reset in the middle of evaluation drops the pending result
        load_image(1'b0, 1'b0, 1'b0);
        C1X = 4'd6; C1Y = 4'd9; C2X = 4'd7; C2Y = 4'd6;
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        repeat (3) tick();
        RST = 1'b0;
        tick();
        RST = 1'b1;
        seen_valid = 1'b0; seen_busy = 1'b0;
        repeat (15) begin
            seen_valid |= SCORE_VALID;
            seen_busy  |= BUSY;
            tick();
        end
        check("rst_eval_no_valid", seen_valid, 0);
        check("rst_eval_no_busy", seen_busy, 0);
        for (int i = 0; i < OBJ_NUM; i++) begin tx[i] = 4'($urandom); ty[i] = 4'($urandom); end
        load_image(1'b1, 1'b0, 1'b0);
        run_image(5, 5, 10, 10, 1);

        // Back-to-back random images with clustered targets
        for (int n = 0; n < 8; n++) begin
            cx = int'($urandom_range(0, 15)); cy = int'($urandom_range(0, 15));
            for (int i = 0; i < OBJ_NUM; i++) begin
                if (i % 2 == 0) begin
                    tx[i] = clamp16(cx + int'($urandom_range(0, 10)) - 5);
                    ty[i] = clamp16(cy + int'($urandom_range(0, 10)) - 5);
                end else begin
                    tx[i] = int'($urandom_range(0, 15)); ty[i] = int'($urandom_range(0, 15));
                end
            end
            load_image(1'($urandom), 1'($urandom), 1'($urandom));
            run_image(cx, cy, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 3)));
        end

        repeat (4) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
